// File: rtl/piso_shift_reg_if.sv
// Load/Ready handshake plus serial-side status for the parallel-in/serial-out shifter.
// The master drives Load/Din; the slave (the shifter) drives Ready/Dout/Busy/Done.
interface piso_shift_reg_if #(
  parameter int WIDTH = 4
);
  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             Ready;
  logic             Dout;
  logic             Busy;
  logic             Done;

  modport master (
    output Load, Din,
    input  Ready, Dout, Busy, Done
  );

  modport slave (
    input  Load, Din,
    output Ready, Dout, Busy, Done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register: a word accepted on Load is sent on Dout one bit
// per clock, followed by a one-cycle Done pulse.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            Clk,
  input  logic            Rst_n,
  piso_shift_reg_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             dout_q,  dout_d;
  logic             accept;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // A Load seen during the Done cycle starts the next frame directly, so a held Load
  // yields back-to-back frames every WIDTH+1 cycles.
  assign accept = bus.Load && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CW'(1);
      if (MSB_FIRST) begin
        dout_d  = bus.Din[WIDTH-1];
        shreg_d = bus.Din << 1;
      end else begin
        dout_d  = bus.Din[0];
        shreg_d = bus.Din >> 1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = DONE;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            if (MSB_FIRST) begin
              dout_d  = shreg_q[WIDTH-1];
              shreg_d = shreg_q << 1;
            end else begin
              dout_d  = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.Ready = (state_q == IDLE);
  assign bus.Busy  = (state_q == SHIFT);
  assign bus.Done  = (state_q == DONE);
  assign bus.Dout  = dout_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Drives an MSB-first and an LSB-first shifter with identical stimulus and checks every
// output each cycle against a frame-position model, plus directed serial-word checks.
module tb_piso_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] din;

  int vectors = 0;
  int errors  = 0;

  // Model: position within the current frame (-1 = idle, 0..W-1 = data bit, W = done).
  int           pos = -1;
  logic [W-1:0] word = '0;

  piso_shift_reg_if #(.WIDTH(W)) if_m ();
  piso_shift_reg_if #(.WIDTH(W)) if_l ();

  assign if_m.Load = load;
  assign if_m.Din  = din;
  assign if_l.Load = load;
  assign if_l.Din  = din;

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (if_m.slave)
  );

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (if_l.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic e_ready, e_busy, e_done, e_dm, e_dl;
    e_ready = (pos < 0);
    e_busy  = (pos >= 0) && (pos < W);
    e_done  = (pos == W);
    e_dm    = e_busy ? word[W-1-pos] : 1'b0;
    e_dl    = e_busy ? word[pos]     : 1'b0;
    chk("msb_ready", if_m.Ready, e_ready);
    chk("msb_busy",  if_m.Busy,  e_busy);
    chk("msb_done",  if_m.Done,  e_done);
    chk("msb_dout",  if_m.Dout,  e_dm);
    chk("lsb_ready", if_l.Ready, e_ready);
    chk("lsb_busy",  if_l.Busy,  e_busy);
    chk("lsb_done",  if_l.Done,  e_done);
    chk("lsb_dout",  if_l.Dout,  e_dl);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      pos = -1;
    end else if ((pos < 0 || pos == W) && load) begin
      pos  = 0;
      word = din;
    end else if (pos == W) begin
      pos = -1;
    end else if (pos >= 0) begin
      pos++;
    end
    #1;
    check_all();
    $display("cyc t=%0t rst_n=%b load=%b din=%h | m:R%bB%bD%bQ%b l:R%bB%bD%bQ%b",
             $time, rst_n, load, din, if_m.Ready, if_m.Busy, if_m.Done, if_m.Dout,
             if_l.Ready, if_l.Busy, if_l.Done, if_l.Dout);
  endtask

  // Run the W data cycles of a frame, collecting Dout with the first bit in the MSB.
  task automatic collect(input logic ld_after, input logic [W-1:0] din_after,
                         output logic [W-1:0] bm, output logic [W-1:0] bl);
    bm = '0;
    bl = '0;
    for (int k = 0; k < W; k++) begin
      step();
      bm = {bm[W-2:0], if_m.Dout};
      bl = {bl[W-2:0], if_l.Dout};
      if (k == 0) begin
        load = ld_after;
        din  = din_after;
      end
    end
  endtask

  initial begin
    logic [W-1:0] bm, bl, w;

    // Reset held with Load high: nothing may be captured.
    rst_n = 1'b0;
    load  = 1'b1;
    din   = 4'hF;
    step();
    step();
    chk("rst_ready", if_m.Ready, 1'b1);
    chk("rst_dout",  if_m.Dout,  1'b0);

    // Single frame 1011.
    rst_n = 1'b1;
    din   = 4'b1011;
    collect(1'b0, 4'b0000, bm, bl);
    chk4("f1011_msb", bm, 4'b1011);
    chk4("f1011_lsb", bl, 4'b1101);
    step();
    chk("f1011_done", if_m.Done, 1'b1);
    step();
    chk("f1011_ready", if_m.Ready, 1'b1);
    step();

    // Load during a frame is ignored until the Done cycle.
    load = 1'b1;
    din  = 4'b1100;
    collect(1'b1, 4'b0011, bm, bl);
    chk4("busy_ign_msb", bm, 4'b1100);
    chk4("busy_ign_lsb", bl, rev(4'b1100));
    step();
    collect(1'b0, 4'b0000, bm, bl);
    chk4("second_msb", bm, 4'b0011);
    chk4("second_lsb", bl, rev(4'b0011));
    step();
    step();

    // Load held high: back-to-back frames alternating A/5.
    load = 1'b1;
    din  = 4'hA;
    for (int f = 0; f < 4; f++) begin
      w = din;
      collect(1'b1, w, bm, bl);
      chk4("b2b_msb", bm, w);
      chk4("b2b_lsb", bl, rev(w));
      din = (w == 4'hA) ? 4'h5 : 4'hA;
      step();
      chk("b2b_done", if_m.Done, 1'b1);
    end
    load = 1'b0;
    step();
    step();

    // Reset mid-frame, then a clean frame after release.
    load = 1'b1;
    din  = 4'b1111;
    step();
    load = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy", if_m.Busy, 1'b0);
    chk("midrst_dout", if_m.Dout, 1'b0);
    rst_n = 1'b1;
    step();
    chk("midrst_nodone", if_m.Done, 1'b0);
    load = 1'b1;
    din  = 4'b0001;
    collect(1'b0, 4'b0000, bm, bl);
    chk4("after_rst_msb", bm, 4'b0001);
    chk4("after_rst_lsb", bl, 4'b1000);
    step();
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      load  = ($urandom_range(0, 2) == 0);
      din   = W'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
